// File: rtl/irpr_pkg.sv
// Shared definitions for the IRPR receive controller: CSR bit positions and FSM states.
package irpr_pkg;

    localparam int unsigned CSR_ERR  = 15;
    localparam int unsigned CSR_RST  = 14;
    localparam int unsigned CSR_DONE = 7;
    localparam int unsigned CSR_IE   = 6;
    localparam int unsigned CSR_FULL = 5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACK,
        R_WAIT
    } rx_state_e;

    typedef enum logic [1:0] {
        I_IDLE,
        I_REQ,
        I_WAIT
    } irq_state_e;

endpackage

// File: rtl/irpr_rx_if.sv
// Wishbone slave bus bundle for irpr_rx; signal names follow the peripheral bus.
interface irpr_rx_if;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/irpr_rx_fifo.sv
// Receive byte buffer: DEPTH-entry FIFO with IRPR_RX_FIFO_EN, else one holding register.
module irpr_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
`ifdef IRPR_RX_FIFO_EN
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full buffer is legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
`else
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop  = pop & valid_q;
        do_push = push & (~valid_q | do_pop);
        data_d  = data_q;
        valid_d = do_push | (valid_q & ~do_pop);
        if (flush) begin
            valid_d = 1'b0;
        end else if (do_push) begin
            data_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = data_q;
    assign empty = ~valid_q;
    assign full  = valid_q;
`endif
endmodule

// File: rtl/irpr_rx.sv
// IRPR receive controller: strobe/ack byte receiver, CSR/DAT Wishbone slave, vectored irq.
// Define IRPR_RX_FIFO_EN for a FIFO_DEPTH-byte buffer; otherwise a single holding register.
module irpr_rx
    import irpr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACK_LEN    = 8,
    parameter int unsigned FILT_LEN   = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    irpr_rx_if.slave   wb,
    output logic       irq,
    input  logic       iack,
    input  logic [7:0] rx_data,
    input  logic       rx_stb_n,
    output logic       rx_busy,
    output logic       rx_ack_n
);
    logic                stb_s1_q, stb_s2_q;
    logic [7:0]          data_s1_q, data_s2_q;
    logic [FILT_LEN-1:0] filt_sh_q, filt_sh_d;
    logic                filt_q, filt_d, stb_fall;
    rx_state_e           rx_state_q, rx_state_d;
    irq_state_e          irq_state_q, irq_state_d;
    logic [7:0]          ack_cnt_q, ack_cnt_d;
    logic                ack_q, ack_d, pop_pend_q, pop_pend_d;
    logic [15:0]         dat_q, dat_d, csr_rd;
    logic                ie_q, ie_d, err_q, err_d, trig_q, trig_d;
    logic                irq_q, irq_d, rx_busy_q, rx_busy_d, rx_ack_n_q, rx_ack_n_d;
    logic                req, wr, flush, pop, push, ovf;
    logic [7:0]          fifo_dout;
    logic                fifo_empty, fifo_full;
    logic                unused_bits;

    assign unused_bits = ^{wb.wb_adr_i[0], wb.wb_dat_i[13:7], wb.wb_dat_i[5:0]};

    irpr_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (data_s2_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Filter looks at the incoming sample so the level flips on the edge that completes the run.
    always_comb begin
        filt_sh_d = {filt_sh_q[FILT_LEN-2:0], stb_s2_q};
        filt_d    = filt_q;
        if (&filt_sh_d) begin
            filt_d = 1'b1;
        end else if (~|filt_sh_d) begin
            filt_d = 1'b0;
        end
        stb_fall = filt_q & ~filt_d;
    end

    always_comb begin
        req    = wb.wb_cyc_i & wb.wb_stb_i;
        ack_d  = req & ~ack_q;
        csr_rd = '0;
        csr_rd[CSR_ERR]  = err_q;
        csr_rd[CSR_DONE] = ~fifo_empty;
        csr_rd[CSR_IE]   = ie_q;
        csr_rd[CSR_FULL] = fifo_full;
        dat_d      = '0;
        pop_pend_d = 1'b0;
        if (req & ~ack_q & ~wb.wb_we_i) begin
            if (!wb.wb_adr_i[1]) begin
                dat_d = csr_rd;
            end else if (!fifo_empty) begin
                dat_d      = {8'h00, fifo_dout};
                pop_pend_d = 1'b1;
            end
        end
        // Pop only what was actually returned; a byte arriving during the wait state stays queued.
        pop   = ack_q & pop_pend_q;
        wr    = ack_q & req & wb.wb_we_i & ~wb.wb_adr_i[1];
        flush = wr & wb.wb_dat_i[CSR_RST];
        ie_d  = wr ? wb.wb_dat_i[CSR_IE] : ie_q;

        rx_state_d = rx_state_q;
        ack_cnt_d  = ack_cnt_q;
        push       = 1'b0;
        ovf        = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                if (stb_fall) begin
                    push       = ~fifo_full | pop;
                    ovf        = fifo_full & ~pop;
                    ack_cnt_d  = '0;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (ack_cnt_q == 8'(ACK_LEN - 1)) begin
                    rx_state_d = R_WAIT;
                end else begin
                    ack_cnt_d = ack_cnt_q + 8'd1;
                end
            end
            R_WAIT: begin
                if (filt_q) begin
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
        if (flush) begin
            rx_state_d = R_WAIT;
            push       = 1'b0;
            ovf        = 1'b0;
        end
        rx_busy_d  = (rx_state_q != R_IDLE) | fifo_full;
        rx_ack_n_d = (rx_state_q != R_ACK);

        err_d = (err_q & ~(wr & (wb.wb_dat_i[CSR_ERR] | wb.wb_dat_i[CSR_RST]))) | ovf;

        irq_state_d = irq_state_q;
        irq_d       = 1'b0;
        trig_d      = trig_q;
        unique case (irq_state_q)
            I_IDLE: begin
                if (ie_q & trig_q) begin
                    irq_d       = 1'b1;
                    irq_state_d = I_REQ;
                end
            end
            I_REQ: begin
                if (!ie_q) begin
                    irq_state_d = I_IDLE;
                end else if (iack) begin
                    trig_d      = 1'b0;
                    irq_state_d = I_WAIT;
                end else begin
                    irq_d = 1'b1;
                end
            end
            I_WAIT: begin
                if (!iack) begin
                    irq_state_d = I_IDLE;
                end
            end
            default: irq_state_d = I_IDLE;
        endcase
        if (push | (wr & wb.wb_dat_i[CSR_IE] & ~ie_q & ~fifo_empty)) begin
            trig_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            stb_s1_q    <= 1'b1;
            stb_s2_q    <= 1'b1;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            filt_sh_q   <= '1;
            filt_q      <= 1'b1;
            rx_state_q  <= R_IDLE;
            irq_state_q <= I_IDLE;
            ack_cnt_q   <= '0;
            ack_q       <= 1'b0;
            pop_pend_q  <= 1'b0;
            dat_q       <= '0;
            ie_q        <= 1'b0;
            err_q       <= 1'b0;
            trig_q      <= 1'b0;
            irq_q       <= 1'b0;
            rx_busy_q   <= 1'b0;
            rx_ack_n_q  <= 1'b1;
        end else begin
            stb_s1_q    <= rx_stb_n;
            stb_s2_q    <= stb_s1_q;
            data_s1_q   <= rx_data;
            data_s2_q   <= data_s1_q;
            filt_sh_q   <= filt_sh_d;
            filt_q      <= filt_d;
            rx_state_q  <= rx_state_d;
            irq_state_q <= irq_state_d;
            ack_cnt_q   <= ack_cnt_d;
            ack_q       <= ack_d;
            pop_pend_q  <= pop_pend_d;
            dat_q       <= dat_d;
            ie_q        <= ie_d;
            err_q       <= err_d;
            trig_q      <= trig_d;
            irq_q       <= irq_d;
            rx_busy_q   <= rx_busy_d;
            rx_ack_n_q  <= rx_ack_n_d;
        end
    end

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign irq         = irq_q;
    assign rx_busy     = rx_busy_q;
    assign rx_ack_n    = rx_ack_n_q;
endmodule
